// File: rtl/cle_key_reader.sv
// Serial key reader: walks the key device through NBITS select pulses and assembles the word MSB-first.
// Optional self-check against EXPECT is enabled by defining CLE_KEY_READER_CHECK_EN.
module cle_key_reader #(
    parameter int NBITS      = 16,
    parameter int SEL_CYCLES = 3
`ifdef CLE_KEY_READER_CHECK_EN
    ,
    parameter logic [NBITS-1:0] EXPECT = '0
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       cmd,
    input  logic             abort,
    input  logic             sdrd,
    output logic             sser,
    output logic             ba13,
    output logic             ba12,
    output logic [3:0]       ba_lo,
    output logic             br_w,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] data
`ifdef CLE_KEY_READER_CHECK_EN
    ,
    output logic             mismatch
`endif
);

    localparam int CNT_W = $clog2(NBITS + 1);
    localparam logic [CNT_W-1:0] NBITS_C  = CNT_W'(NBITS);
    localparam logic [3:0]       SEL_LAST = 4'(SEL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SELECT,
        RELEASE,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cmd_q;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_inc;
    logic [3:0]       sel_cnt;
    logic [NBITS-1:0] shreg;
    logic             aborted;
    logic             sel_last;
    logic             more_bits;
    logic             finishing;

    assign bit_cnt_inc = bit_cnt + CNT_W'(1);
    assign more_bits   = (bit_cnt_inc < NBITS_C);
    assign sel_last    = (sel_cnt == SEL_LAST);
    assign finishing   = (state == RELEASE) && !aborted && !more_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus values are decoded from the state alone, so sser and the address
    // only ever change together on the SETUP/RELEASE boundaries where sser is high.
    always_comb begin
        state_nxt = state;
        sser      = 1'b1;
        ba13      = 1'b1;
        ba12      = 1'b0;
        ba_lo     = 4'b0000;
        br_w      = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                ba13  = 1'b0;
                ba12  = 1'b1;
                ba_lo = cmd_q;
                br_w  = 1'b1;
                state_nxt = abort ? RELEASE : SELECT;
            end
            SELECT: begin
                ba13  = 1'b0;
                ba12  = 1'b1;
                ba_lo = cmd_q;
                br_w  = 1'b1;
                sser  = 1'b0;
                if (abort || sel_last) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                ba13  = 1'b0;
                ba12  = 1'b1;
                ba_lo = cmd_q;
                br_w  = 1'b1;
                if (aborted) begin
                    state_nxt = IDLE;
                end else if (more_bits) begin
                    state_nxt = SETUP;
                end else begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: data is loaded on the edge entering FINISH so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q   <= 4'b0000;
            bit_cnt <= '0;
            sel_cnt <= 4'd0;
            shreg   <= '0;
            aborted <= 1'b0;
            data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_q   <= cmd;
                        bit_cnt <= '0;
                        shreg   <= '0;
                        aborted <= 1'b0;
                    end
                end
                SETUP: begin
                    sel_cnt <= 4'd0;
                    if (abort) begin
                        aborted <= 1'b1;
                    end
                end
                SELECT: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else begin
                        sel_cnt <= sel_cnt + 4'd1;
                        if (sel_last) begin
                            shreg <= (shreg << 1) | NBITS'(sdrd);
                        end
                    end
                end
                RELEASE: begin
                    bit_cnt <= bit_cnt_inc;
                    if (finishing) begin
                        data <= shreg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CLE_KEY_READER_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (state == IDLE && start) begin
            mismatch <= 1'b0;
        end else if (finishing) begin
            mismatch <= (shreg != EXPECT);
        end
    end
`endif

endmodule

// File: tb/tb_cle_key_reader.sv
// Directed bench for cle_key_reader: table of full transactions plus abort, reset and minimum-size corners.
module tb_cle_key_reader;

    localparam int NB  = 16;
    localparam int SEL = 3;
    localparam int LAT = 81;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  cmd;
    logic        abort;
    logic        sdrd;
    logic        sser;
    logic        ba13;
    logic        ba12;
    logic [3:0]  ba_lo;
    logic        br_w;
    logic        busy;
    logic        done;
    logic [15:0] data;
    logic        mm;

    logic        s_start;
    logic [3:0]  s_cmd;
    logic        s_abort;
    logic        s_sdrd;
    logic        s_sser;
    logic        s_ba13;
    logic        s_ba12;
    logic [3:0]  s_ba_lo;
    logic        s_br_w;
    logic        s_busy;
    logic        s_done;
    logic [0:0]  s_data;
    logic        s_mm;

    int n_checks = 0;
    int n_fail   = 0;

    cle_key_reader #(
        .NBITS      (NB),
        .SEL_CYCLES (SEL)
`ifdef CLE_KEY_READER_CHECK_EN
        ,
        .EXPECT     (16'hA5C3)
`endif
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cmd   (cmd),
        .abort (abort),
        .sdrd  (sdrd),
        .sser  (sser),
        .ba13  (ba13),
        .ba12  (ba12),
        .ba_lo (ba_lo),
        .br_w  (br_w),
        .busy  (busy),
        .done  (done),
        .data  (data)
`ifdef CLE_KEY_READER_CHECK_EN
        ,
        .mismatch (mm)
`endif
    );

    cle_key_reader #(
        .NBITS      (1),
        .SEL_CYCLES (1)
    ) u_small (
        .clk   (clk),
        .rst   (rst),
        .start (s_start),
        .cmd   (s_cmd),
        .abort (s_abort),
        .sdrd  (s_sdrd),
        .sser  (s_sser),
        .ba13  (s_ba13),
        .ba12  (s_ba12),
        .ba_lo (s_ba_lo),
        .br_w  (s_br_w),
        .busy  (s_busy),
        .done  (s_done),
        .data  (s_data)
`ifdef CLE_KEY_READER_CHECK_EN
        ,
        .mismatch (s_mm)
`endif
    );

`ifndef CLE_KEY_READER_CHECK_EN
    assign mm   = 1'b0;
    assign s_mm = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  cmd;
        logic [15:0] pattern;
        logic [15:0] exp_data;
        bit          start_busy;
        bit          abort_start;
        bit          abort_rel;
    } vec_t;

    vec_t vecs[5];

    // Per-cycle tracking of sser pulses and the sdrd bit to present
    int          tr_pulses;
    int          tr_w;
    int          tr_werr;
    logic        tr_prev_sser;
    logic [15:0] tr_pattern;

    // Results of the most recent run_txn
    int          r_lat;
    int          r_done_cnt;
    int          r_bus_err;
    logic [15:0] r_data_done;
    logic [15:0] r_data_after;
    logic        r_busy_after;
    logic        r_mm_done;
    logic        r_mm_after;
    logic        r_mm_k1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tr_reset(input logic [15:0] pat);
        tr_pulses    = 0;
        tr_w         = 0;
        tr_werr      = 0;
        tr_prev_sser = 1'b1;
        tr_pattern   = pat;
    endtask

    task automatic track();
        if (sser == 1'b0) begin
            tr_w++;
        end else if (tr_prev_sser == 1'b0) begin
            tr_pulses++;
            if (tr_w != SEL) tr_werr++;
            tr_w = 0;
        end
        tr_prev_sser = sser;
        sdrd = (tr_pulses < NB) ? tr_pattern[NB-1-tr_pulses] : 1'b0;
    endtask

    task automatic run_txn(input logic [3:0] c, input logic [15:0] pat,
                           input bit sb, input bit ab_start, input bit ab_rel);
        logic [6:0] prev_bus;
        logic       rel_now;
        tr_reset(pat);
        r_lat        = 0;
        r_done_cnt   = 0;
        r_bus_err    = 0;
        r_data_done  = ~pat;
        r_data_after = ~pat;
        r_busy_after = 1'b1;
        r_mm_done    = 1'bx;
        r_mm_after   = 1'bx;
        r_mm_k1      = 1'bx;
        @(negedge clk);
        cmd      = c;
        start    = 1'b1;
        abort    = ab_start;
        prev_bus = {ba13, ba12, ba_lo, br_w};
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            rel_now = sser && !tr_prev_sser;
            track();
            start = sb && (k == 20);
            abort = ab_rel && rel_now && (tr_pulses == 3);
            if (k == 1) r_mm_k1 = mm;
            if (busy && !done && ({ba13, ba12, br_w} !== 3'b011 || ba_lo !== c)) r_bus_err++;
            if ({ba13, ba12, ba_lo, br_w} !== prev_bus && !sser) r_bus_err++;
            prev_bus = {ba13, ba12, ba_lo, br_w};
            if (done) begin
                r_done_cnt++;
                if (r_lat == 0) begin
                    r_lat       = k;
                    r_data_done = data;
                    r_mm_done   = mm;
                end
            end
            if (r_lat != 0 && k == r_lat + 1) r_busy_after = busy;
            if (r_lat != 0 && k == r_lat + 3) begin
                r_data_after = data;
                r_mm_after   = mm;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        logic [9:0] rst_vec;
        bit         sent;
        int         c_ab;
        int         dcnt;
        logic       sser1;
        logic       busy1;
        logic       busy2;
        int         s_lat;
        int         s_low;
        logic [0:0] s_d;
        logic       b;

        vecs[0] = '{4'b1010, 16'hA5C3, 16'hA5C3, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b0101, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'b1111, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{4'b0001, 16'h8001, 16'h8001, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{4'b0110, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1};

        rst     = 1'b1;
        start   = 1'b0;
        cmd     = 4'b0000;
        abort   = 1'b0;
        sdrd    = 1'b0;
        s_start = 1'b0;
        s_cmd   = 4'b0000;
        s_abort = 1'b0;
        s_sdrd  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({sser, ba13, ba12, ba_lo, br_w, busy, done}), 32'b1100000000);
        check("reset_data", 32'(data), 32'h0);
        rst = 1'b0;

        // Table of complete transactions
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].cmd, vecs[i].pattern, vecs[i].start_busy, vecs[i].abort_start, vecs[i].abort_rel);
            check($sformatf("v%0d_latency", i), 32'(r_lat), 32'(LAT));
            check($sformatf("v%0d_data", i), 32'(r_data_done), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_pulses", i), 32'(tr_pulses), 32'(NB));
            check($sformatf("v%0d_width_err", i), 32'(tr_werr), 32'h0);
            check($sformatf("v%0d_bus_err", i), 32'(r_bus_err), 32'h0);
            check($sformatf("v%0d_done_cnt", i), 32'(r_done_cnt), 32'h1);
            check($sformatf("v%0d_idle_after", i), 32'(r_busy_after), 32'h0);
            check($sformatf("v%0d_data_held", i), 32'(r_data_after), 32'(vecs[i].exp_data));
`ifdef CLE_KEY_READER_CHECK_EN
            if (i == 0) check("v0_mismatch", 32'(r_mm_done), 32'h0);
`endif
        end

        // Abort in the first SELECT cycle of the 5th bit
        tr_reset(16'hFFFF);
        sent  = 1'b0;
        c_ab  = 0;
        dcnt  = 0;
        sser1 = 1'b0;
        busy1 = 1'b0;
        busy2 = 1'b1;
        @(negedge clk);
        cmd   = 4'b1010;
        start = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            track();
            start = 1'b0;
            abort = 1'b0;
            if (done) dcnt++;
            if (sent && k == c_ab + 1) begin
                sser1 = sser;
                busy1 = busy;
            end
            if (sent && k == c_ab + 2) busy2 = busy;
            if (!sent && tr_pulses == 4 && !sser) begin
                abort = 1'b1;
                sent  = 1'b1;
                c_ab  = k;
            end
            if (sent && k == c_ab + 40) break;
        end
        abort = 1'b0;
        check("abort_reached", 32'(sent), 32'h1);
        check("abort_sser_released", 32'(sser1), 32'h1);
        check("abort_release_busy", 32'(busy1), 32'h1);
        check("abort_idle", 32'(busy2), 32'h0);
        check("abort_no_done", 32'(dcnt), 32'h0);
        check("abort_data_kept", 32'(data), 32'h1234);

        // Reset during the 10th bit
        tr_reset(16'hFFFF);
        sent = 1'b0;
        @(negedge clk);
        cmd   = 4'b1100;
        start = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            track();
            start = 1'b0;
            if (!sent && tr_pulses == 9 && !sser) begin
                rst  = 1'b1;
                sent = 1'b1;
                break;
            end
        end
        @(negedge clk);
        rst_vec = {sser, ba13, ba12, ba_lo, br_w, busy, done};
        check("midrst_reached", 32'(sent), 32'h1);
        check("midrst_outputs", 32'(rst_vec), 32'b1100000000);
        check("midrst_data", 32'(data), 32'h0);
        rst = 1'b0;
        run_txn(4'b0011, 16'h5A3C, 1'b0, 1'b0, 1'b0);
        check("postrst_latency", 32'(r_lat), 32'(LAT));
        check("postrst_data", 32'(r_data_done), 32'h5A3C);
        check("postrst_done_cnt", 32'(r_done_cnt), 32'h1);

        // Minimum configuration: NBITS=1, SEL_CYCLES=1
        for (int j = 0; j < 2; j++) begin
            b      = (j == 0);
            s_sdrd = b;
            s_lat  = 0;
            s_low  = 0;
            s_d    = ~b;
            @(negedge clk);
            s_cmd   = 4'b0110;
            s_start = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                s_start = 1'b0;
                if (!s_sser) s_low++;
                if (s_done && s_lat == 0) begin
                    s_lat = k;
                    s_d   = s_data;
                end
            end
            check($sformatf("small%0d_latency", j), 32'(s_lat), 32'h4);
            check($sformatf("small%0d_data", j), 32'(s_d), 32'(b));
            check($sformatf("small%0d_sser_low", j), 32'(s_low), 32'h1);
        end

`ifdef CLE_KEY_READER_CHECK_EN
        run_txn(4'b1010, 16'hA5C2, 1'b0, 1'b0, 1'b0);
        check("chk_bad_data", 32'(r_data_done), 32'hA5C2);
        check("chk_bad_mismatch", 32'(r_mm_done), 32'h1);
        check("chk_bad_held", 32'(r_mm_after), 32'h1);
        run_txn(4'b1010, 16'hA5C3, 1'b0, 1'b0, 1'b0);
        check("chk_cleared_on_start", 32'(r_mm_k1), 32'h0);
        check("chk_good_mismatch", 32'(r_mm_done), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
